seq_divider: RTL and testbench

- Sequential restoring divider that is the inverse datapath of the shift-and-add multiplier.
- Accepts an unsigned dividend/divisor pair over a single-cycle `in_valid` strobe, iterates one quotient bit per cycle, then pulses `out_valid` with quotient and remainder.
- Sits beside the multiplier as a second arithmetic unit in the two-copy timing-equivalence harnesses. Its latency depends on the operands unless constant-time mode is compiled in.

---
 rtl/seq_divider.sv | 104 ++++++++++
 tb/tb_seq_divider.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, registered results.
// Define SEQ_DIVIDER_CONST_TIME_EN to remove early termination (constant latency).
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             out_valid,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] qsr_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [CntW-1:0]  cnt_q;

    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] qsr_next;
    logic             rem_ge;
    logic             early;

    always_comb begin
        rem_shift = {rem_q[WIDTH-2:0], qsr_q[WIDTH-1]};
        rem_ge    = (rem_shift >= dvsr_q);
        rem_next  = rem_ge ? (rem_shift - dvsr_q) : rem_shift;
        qsr_next  = {qsr_q[WIDTH-2:0], rem_ge};
    end

`ifdef SEQ_DIVIDER_CONST_TIME_EN
    assign early = 1'b0;
`else
    // Only meaningful on the first BUSY edge, while qsr still holds the dividend.
    assign early = (cnt_q == '0) &&
                   ((dvsr_q == '0) || (qsr_q == '0) || (qsr_q < dvsr_q));
`endif

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q     <= StIdle;
            qsr_q       <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            cnt_q       <= '0;
            q           <= '0;
            r           <= '0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        qsr_q   <= a;
                        dvsr_q  <= b;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (early) begin
                        q           <= (dvsr_q == '0) ? '1 : '0;
                        r           <= qsr_q;
                        div_by_zero <= (dvsr_q == '0);
                        out_valid   <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        qsr_q <= qsr_next;
                        rem_q <= rem_next;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LastIter) begin
                            q           <= qsr_next;
                            r           <= rem_next;
                            div_by_zero <= (dvsr_q == '0);
                            out_valid   <= 1'b1;
                            state_q     <= StDone;
                        end
                    end
                end
                StDone: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH = 32).
module tb_seq_divider;

    localparam int W = 32;
`ifdef SEQ_DIVIDER_CONST_TIME_EN
    localparam int EarlyL = 32;
`else
    localparam int EarlyL = 1;
`endif

    logic         in_clk = 1'b0;
    logic         in_rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         busy;
    logic         out_valid;
    logic         div_by_zero;

    int vecs = 0;
    int errs = 0;

    seq_divider #(.WIDTH(W)) dut (
        .in_clk      (in_clk),
        .in_rst_n    (in_rst_n),
        .in_valid    (in_valid),
        .a           (a),
        .b           (b),
        .q           (q),
        .r           (r),
        .busy        (busy),
        .out_valid   (out_valid),
        .div_by_zero (div_by_zero)
    );

    always #5 in_clk = ~in_clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept an operation, wait for out_valid and check results, latency, pulse width.
    // With junk set, in_valid is held high with a=7,b=7 throughout BUSY.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                          input int el, input bit junk);
        int lat;
        lat = 0;
        @(negedge in_clk);
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(posedge in_clk);
        #1;
        if (junk) begin
            a = 7;
            b = 7;
        end else begin
            in_valid = 1'b0;
        end
        for (int n = 1; n <= 40; n++) begin
            @(posedge in_clk);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        in_valid = 1'b0;
        chk({tag, " latency"}, lat, el);
        chk({tag, " q"}, q, eq);
        chk({tag, " r"}, r, er);
        chk({tag, " dbz"}, {31'b0, div_by_zero}, {31'b0, edz});
        chk({tag, " busy_done"}, {31'b0, busy}, 32'd1);
        @(posedge in_clk);
        #1;
        chk({tag, " pulse_width"}, {31'b0, out_valid}, 32'd0);
        chk({tag, " busy_idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int seen;
        // Reset state
        repeat (3) @(posedge in_clk);
        #1;
        chk("rst q", q, 0);
        chk("rst r", r, 0);
        chk("rst flags", {29'b0, busy, out_valid, div_by_zero}, 0);
        @(negedge in_clk);
        in_rst_n = 1'b1;

        run_op("100/7", 100, 7, 14, 2, 1'b0, 32, 1'b0);
        run_op("5/0", 5, 0, 32'hFFFF_FFFF, 5, 1'b1, EarlyL, 1'b0);
        run_op("3/10", 3, 10, 0, 3, 1'b0, EarlyL, 1'b0);
        run_op("0/9", 0, 9, 0, 0, 1'b0, EarlyL, 1'b0);
        run_op("max/1", 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 1'b0, 32, 1'b0);
        run_op("msb/max", 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 1'b0, EarlyL, 1'b0);

        // Operands offered while busy are dropped; back-to-back accept then succeeds
        run_op("1000/3 junk", 1000, 3, 333, 1, 1'b0, 32, 1'b1);
        run_op("b2b 100/7", 100, 7, 14, 2, 1'b0, 32, 1'b0);

        // Reset mid-operation at iteration 10
        @(negedge in_clk);
        in_valid = 1'b1;
        a = 1000;
        b = 3;
        @(posedge in_clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge in_clk);
        @(negedge in_clk);
        in_rst_n = 1'b0;
        @(posedge in_clk);
        #1;
        chk("midrst q", q, 0);
        chk("midrst r", r, 0);
        chk("midrst flags", {29'b0, busy, out_valid, div_by_zero}, 0);
        @(negedge in_clk);
        in_rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge in_clk);
            #1;
            if (out_valid) seen++;
        end
        chk("midrst no_valid", seen, 0);
        run_op("post-rst 1000/3", 1000, 3, 333, 1, 1'b0, 32, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
